// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_WAIT = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        PARITY     = 3'd4,
        STOP       = 3'd5
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer_baud_edge_det.sv
// Rising-edge detector for the clk-synchronous baud square wave; emits a registered one-clk tick.
module baud_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_clk,
    output logic tick
);

    logic baud_prev_q;
    logic tick_q;

    // baud_prev resets high so a baud_clk already high at release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_prev_q <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            baud_prev_q <= baud_clk;
            tick_q      <= baud_clk & ~baud_prev_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serialiser: start bit, DATA_BITS LSB first, STOP_BITS stop bits, paced by baud ticks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// Handshake: a byte is accepted when din_valid && din_ready at a clk edge; din_ready is
// high only while IDLE, and din_valid at any other time is ignored (no queuing).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 ready_q, ready_d;
    logic                 tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    baud_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    assign accept = din_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                // A tick coinciding with accept is deliberately skipped: START_WAIT waits for the next one.
                if (accept) begin
                    shift_d    = din;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START_WAIT;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^din;
`endif
                end
            end
            START_WAIT: begin
                if (tick) begin
                    tx_d    = UART_START_LVL;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d       = UART_IDLE_LVL;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d       = UART_IDLE_LVL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
            tx_done_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            ready_q    <= ready_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx        = tx_q;
    assign tx_done   = tx_done_q;
    assign din_ready = ready_q;
    assign busy      = (state_q != IDLE) || accept;
    assign dbg_state = state_q;

endmodule
